vertex_streamer: RTL
====================

VERTEX_STREAMER -- requirements
Module: vertex_streamer

Interface
REQ-001 Parameter DIM, default 2, number of 32-bit coordinate words per vertex.
REQ-002 Parameter FIFO_DEPTH, default 4, response buffer depth in words; power of two, at least 2.
REQ-003 clk_in  input  1  single clock; all logic on posedge.
REQ-004 rst_in  input  1  reset; asynchronous assert, active-low (0 = reset).
REQ-005 start_in  input  1  one-cycle pulse; launches a stream.
REQ-006 first_vertex_in  input  32  index of the first vertex; sampled with start_in.
REQ-007 count_in  input  16  number of vertices to stream; sampled with start_in.
REQ-008 hold_in  input  1  consumer stall; no word is emitted while high.
REQ-009 mem_req_out  output  32  word address of the memory read.
REQ-010 mem_valid_out  output  1  read request strobe, one per word.
REQ-011 mem_data_in  input  32  read data; responses return in request order.
REQ-012 mem_valid_in  input  1  read data strobe; latency is 1 or more cycles and may vary.
REQ-013 vertex_out  output  32  coordinate word.
REQ-014 vertex_addr_out  output  32  vertex index of vertex_out.
REQ-015 vertex_valid_out  output  1  vertex_out and vertex_addr_out valid this cycle.
REQ-016 busy_out  output  1  high from the cycle after an accepted start until done.
REQ-017 done_out  output  1  one-cycle pulse after the last word is emitted.

Function
REQ-018 The block SHALL implement states IDLE, RUN, DRAIN and DONE.
- IDLE->RUN: start_in with count_in>0.
- IDLE->DONE: start_in with count_in=0.
- RUN->DRAIN: last request issued.
- DRAIN->DONE: last word emitted.
- DONE->IDLE: after one cycle.
REQ-019 The block SHALL ignore start_in outside IDLE.
REQ-020 Word d of vertex v SHALL be requested at address v*DIM+d, computed mod 2^32; the request order is d=0..DIM-1 for each vertex, and vertices first_vertex_in..first_vertex_in+count_in-1 in order.
REQ-021 The block SHALL issue at most one request per cycle, and only while outstanding+fifo_occupancy<FIFO_DEPTH, so no response is ever dropped.
REQ-022 Every mem_valid_in SHALL push mem_data_in into the FIFO; the FIFO SHALL support push and pop in the same cycle.
REQ-023 The block SHALL emit one word per cycle while the FIFO is not empty and hold_in=0; the output is registered, so the word appears 1 cycle after pop-eligibility.
REQ-024 With latency 1 and hold_in=0, sustained throughput SHALL be one word per cycle.
REQ-025 vertex_addr_out SHALL hold the same index for all DIM words of a vertex, and vertex_valid_out SHALL deassert when no word is emitted.
REQ-026 When outstanding=0, the block SHALL discard mem_valid_in.
REQ-027 done_out SHALL be asserted exactly once per accepted start, and never while words remain.
REQ-028 Vertex indices SHALL wrap modulo 2^32.

Reset
REQ-029 While rst_in=0, the block SHALL be in state IDLE with all counters, FIFO pointers and outstanding count at 0.
REQ-030 While rst_in=0, all outputs SHALL be 0.
REQ-031 After a reset mid-stream, the block SHALL discard responses still in flight, per REQ-026, and SHALL NOT emit words or done_out.

Configuration
REQ-032 When macro VSTREAM_LAST_EN is defined, the block SHALL add output vertex_last_out (1 bit, reset 0), high with vertex_valid_out on word DIM-1 of each vertex.
REQ-033 When VSTREAM_LAST_EN is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Basic stream: DIM=2, start with first=5, count=2, latency 1 -> requests at 10,11,12,13; outputs (data,addr) ordered (d10,5),(d11,5),(d12,6),(d13,6) on consecutive cycles; done_out one cycle after the last word.
REQ-035 Zero count: start with count=0 -> no mem_valid_out; done_out 1-2 cycles later; busy_out returns to 0.
REQ-036 Backpressure: hold_in=1 for 10 cycles mid-stream with latency 3 -> requests stop after 4 outstanding+buffered words; no word lost or duplicated; order preserved after release.
REQ-037 Variable latency: random latency 1-7 over count=50 -> exactly 100 words in address order, and outstanding+occupancy never exceeds 4.
REQ-038 Reset mid-stream: rst_in=0 after 3 requests, released, then responses arrive -> no vertex_valid_out or done_out; a new start then streams correctly.
REQ-039 Configuration: with VSTREAM_LAST_EN defined and DIM=3, count=2 -> vertex_last_out high on the 3rd and 6th words only.

Source files
------------

// File: rtl/vertex_streamer.sv
// Vertex streamer: fetches DIM-word vertices from memory and streams them
// to a consumer through a response FIFO, with a vertex index on each word.
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   start_in, first_vertex_in, count_in : stream launch
//   hold_in                             : consumer stall
//   mem_req_out, mem_valid_out          : read request (one word per strobe)
//   mem_data_in, mem_valid_in           : in-order read responses
//   vertex_out, vertex_addr_out,
//   vertex_valid_out                    : emitted word and its vertex index
//   vertex_last_out                     : last word of a vertex
//                                         (only with VSTREAM_LAST_EN)
//   busy_out, done_out                  : stream status
//
// Build option: define VSTREAM_LAST_EN to add vertex_last_out.
module vertex_streamer #(
    parameter int DIM        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [31:0] first_vertex_in,
    input  logic [15:0] count_in,
    input  logic        hold_in,
    output logic [31:0] mem_req_out,
    output logic        mem_valid_out,
    input  logic [31:0] mem_data_in,
    input  logic        mem_valid_in,
    output logic [31:0] vertex_out,
    output logic [31:0] vertex_addr_out,
    output logic        vertex_valid_out,
`ifdef VSTREAM_LAST_EN
    output logic        vertex_last_out,
`endif
    output logic        busy_out,
    output logic        done_out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam int WW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    logic [31:0]   req_addr;
    logic [31:0]   req_left;
    logic [31:0]   emit_left;
    logic [31:0]   out_vtx;
    logic [WW-1:0] out_word;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          last_word;
    logic [OW-1:0] occ;

    // Requests are throttled on words in flight plus words buffered, so
    // every response always has a FIFO slot waiting for it.
    always_comb begin
        occ       = {1'b0, outstanding} + {1'b0, fifo_cnt};
        issue     = (state == RUN) && (occ < OW'(FIFO_DEPTH));
        push      = mem_valid_in && (outstanding != '0);
        pop       = ((state == RUN) || (state == DRAIN)) &&
                    (fifo_cnt != '0) && !hold_in;
        last_word = (out_word == WW'(DIM - 1));
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            req_addr         <= '0;
            req_left         <= '0;
            emit_left        <= '0;
            out_vtx          <= '0;
            out_word         <= '0;
            outstanding      <= '0;
            fifo_cnt         <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            mem_req_out      <= '0;
            mem_valid_out    <= 1'b0;
            vertex_out       <= '0;
            vertex_addr_out  <= '0;
            vertex_valid_out <= 1'b0;
`ifdef VSTREAM_LAST_EN
            vertex_last_out  <= 1'b0;
`endif
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            done_out         <= 1'b0;
            mem_valid_out    <= issue;
            vertex_valid_out <= pop;
`ifdef VSTREAM_LAST_EN
            vertex_last_out  <= pop && last_word;
`endif

            if (issue) begin
                mem_req_out <= req_addr;
                req_addr    <= req_addr + 32'd1;
                req_left    <= req_left - 32'd1;
            end

            if (issue && !push) begin
                outstanding <= outstanding + CW'(1);
            end else if (!issue && push) begin
                outstanding <= outstanding - CW'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end

            if (pop) begin
                vertex_out      <= fifo_mem[rd_ptr];
                vertex_addr_out <= out_vtx;
                rd_ptr          <= rd_ptr + AW'(1);
                emit_left       <= emit_left - 32'd1;
                if (last_word) begin
                    out_word <= '0;
                    out_vtx  <= out_vtx + 32'd1;
                end else begin
                    out_word <= out_word + WW'(1);
                end
            end

            unique case (state)
                IDLE: begin
                    if (start_in) begin
                        // Vertex words are contiguous, so one base
                        // address plus an increment covers the stream.
                        req_addr  <= first_vertex_in * 32'(DIM);
                        req_left  <= 32'(count_in) * 32'(DIM);
                        emit_left <= 32'(count_in) * 32'(DIM);
                        out_vtx   <= first_vertex_in;
                        out_word  <= '0;
                        busy_out  <= 1'b1;
                        state     <= (count_in == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issue && (req_left == 32'd1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (emit_left == 32'd1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
